// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver:
// scan FSM state encoding, active-low segment constants and the BCD decode.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        GAP_TO_ONES = 2'd0,
        SHOW_ONES   = 2'd1,
        GAP_TO_TENS = 2'd2,
        SHOW_TENS   = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    // Active-low decode, seg[0]=a .. seg[6]=g; codes 10..15 are not BCD and show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit BCD to active-low seven-segment decoder.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup through the shared decode function.
    always_comb begin
        seg = seg_decode(digit);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Two-digit common-anode scan driver: latches the BCD digits on load, then
// alternates ones/tens slots of REFRESH_DIV cycles, separated by GAP_CYCLES
// of all-dark to suppress ghosting. seg and an are registered pin drivers.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] digit_ones,
    input  logic [3:0] digit_tens,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       ones_q;
    logic [3:0]       tens_q;
    scan_state_t      state_r;
    scan_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       dec_in_s;
    logic [6:0]       dec_seg_s;
    logic [6:0]       seg_nxt_s;
    logic [1:0]       an_nxt_s;
    logic [6:0]       seg_r;
    logic [1:0]       an_r;

    // Digit latches: both digits captured together so the pair stays coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else if (load) begin
            ones_q <= digit_ones;
            tens_q <= digit_tens;
        end else begin
            ones_q <= ones_q;
            tens_q <= tens_q;
        end
    end

    // Scan state and slot counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= GAP_TO_ONES;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state: each slot ends on its last count; counter restarts on every change.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        case (state_r)
            GAP_TO_ONES: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = SHOW_ONES;
                end else begin
                    state_nxt_s = GAP_TO_ONES;
                end
            end
            SHOW_ONES: begin
                if (cnt_r == SHOW_LAST) begin
                    state_nxt_s = GAP_TO_TENS;
                end else begin
                    state_nxt_s = SHOW_ONES;
                end
            end
            GAP_TO_TENS: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = SHOW_TENS;
                end else begin
                    state_nxt_s = GAP_TO_TENS;
                end
            end
            SHOW_TENS: begin
                if (cnt_r == SHOW_LAST) begin
                    state_nxt_s = GAP_TO_ONES;
                end else begin
                    state_nxt_s = SHOW_TENS;
                end
            end
            default: begin
                state_nxt_s = GAP_TO_ONES;
            end
        endcase
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Single shared decoder: feed it whichever digit the current slot shows.
    always_comb begin
        dec_in_s = ones_q;
        if (state_r == SHOW_TENS) begin
            dec_in_s = tens_q;
        end else begin
            dec_in_s = ones_q;
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (dec_in_s),
        .seg   (dec_seg_s)
    );

    // Pin values for the next cycle; blank_lz is used live, not latched.
    always_comb begin
        seg_nxt_s = SEG_BLANK;
        an_nxt_s  = AN_OFF;
        case (state_r)
            GAP_TO_ONES, GAP_TO_TENS: begin
                seg_nxt_s = SEG_BLANK;
                an_nxt_s  = AN_OFF;
            end
            SHOW_ONES: begin
                seg_nxt_s = dec_seg_s;
                an_nxt_s  = AN_ONES;
            end
            SHOW_TENS: begin
                an_nxt_s = AN_TENS;
                if (blank_lz && (tens_q == 4'd0)) begin
                    seg_nxt_s = SEG_BLANK;
                end else begin
                    seg_nxt_s = dec_seg_s;
                end
            end
            default: begin
                seg_nxt_s = SEG_BLANK;
                an_nxt_s  = AN_OFF;
            end
        endcase
    end

    // Output registers so the board pins never see decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= AN_OFF;
        end else begin
            seg_r <= seg_nxt_s;
            an_r  <= an_nxt_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with REFRESH_DIV=4, GAP_CYCLES=1.
// A fixed vector table covers the directed scenarios; a random phase follows.
// Every step is also checked against a slot-position model: after the n-th
// edge since reset release, the pins reflect position n mod period.
module tb_seven_seg_scan_driver;

    localparam int RD  = 4;
    localparam int GP  = 1;
    localparam int PER = 2 * (RD + GP);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] digit_ones = 4'd0;
    logic [3:0] digit_tens = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;

    int total = 0;
    int bad   = 0;

    logic [6:0] ref_dec [16];
    int         m_n = 0;
    logic [3:0] m_ones = 4'd0;
    logic [3:0] m_tens = 4'd0;

    typedef struct {
        logic       r;
        logic       ld;
        logic [3:0] o;
        logic [3:0] t;
        logic       b;
        logic [1:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.REFRESH_DIV(RD), .GAP_CYCLES(GP)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digit_ones (digit_ones),
        .digit_tens (digit_tens),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an)
    );

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] o,
                                input logic [3:0] t, input logic b,
                                input logic [1:0] a, input logic [6:0] s);
        vec_t v;
        v.r = r; v.ld = ld; v.o = o; v.t = t; v.b = b; v.an = a; v.seg = s;
        return v;
    endfunction

    // Apply one clock of inputs, predict from the model, then check after the edge.
    task automatic step(input logic r, input logic ld, input logic [3:0] o,
                        input logic [3:0] t, input logic b, input string tag);
        logic [1:0] ea;
        logic [6:0] es;
        int pos;
        rst = r; load = ld; digit_ones = o; digit_tens = t; blank_lz = b;
        ea = 2'b11;
        es = 7'h7F;
        if (r) begin
            m_ones = 4'd0;
            m_tens = 4'd0;
            m_n    = 0;
        end else begin
            pos = m_n % PER;
            if (pos < GP) begin
                ea = 2'b11; es = 7'h7F;
            end else if (pos < GP + RD) begin
                ea = 2'b10; es = ref_dec[m_ones];
            end else if (pos < 2 * GP + RD) begin
                ea = 2'b11; es = 7'h7F;
            end else begin
                ea = 2'b01;
                es = (b && (m_tens == 4'd0)) ? 7'h7F : ref_dec[m_tens];
            end
            m_n++;
            if (ld) begin
                m_ones = o;
                m_tens = t;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_model_an"}, {5'd0, an}, {5'd0, ea});
        chk({tag, "_model_seg"}, seg, es);
        chk({tag, "_an_exclusive"}, {6'd0, (an == 2'b00)}, 7'd0);
    endtask

    initial begin
        ref_dec[0]  = 7'b1000000; ref_dec[1]  = 7'b1111001;
        ref_dec[2]  = 7'b0100100; ref_dec[3]  = 7'b0110000;
        ref_dec[4]  = 7'b0011001; ref_dec[5]  = 7'b0010010;
        ref_dec[6]  = 7'b0000010; ref_dec[7]  = 7'b1111000;
        ref_dec[8]  = 7'b0000000; ref_dec[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) ref_dec[i] = 7'b0111111;

        // Reset, then free-run with digits at 0.
        repeat (2) vq.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E0
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'h40)); // E1-E4
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E5
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, 7'h40)); // E6-E9
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E10
        // Load 7/1 inside the ones slot; the next edge shows the new digit.
        vq.push_back(mk(1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 2'b10, 7'h40));            // E11
        repeat (3) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'h78));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, 7'h79));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E20
        // Load 5/0 with leading-zero blanking: tens anode on, segments dark.
        vq.push_back(mk(1'b0, 1'b1, 4'd5, 4'd0, 1'b1, 2'b10, 7'h78));            // E21
        repeat (3) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'b10, 7'h12));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'b11, 7'h7F));
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 2'b01, 7'h7F));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E30
        // Invalid ones digit shows a dash; blanking off shows tens 0.
        vq.push_back(mk(1'b0, 1'b1, 4'd12, 4'd0, 1'b0, 2'b10, 7'h12));           // E31
        repeat (3) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'h3F));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, 7'h40));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E40
        // Mid-slot reload 8 -> 3: immediate update, slot end unchanged.
        vq.push_back(mk(1'b0, 1'b1, 4'd8, 4'd0, 1'b0, 2'b10, 7'h3F));            // E41
        vq.push_back(mk(1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 2'b10, 7'h00));            // E42
        repeat (2) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'h30));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E45
        // Reset during the tens slot, then restart from the gap.
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, 7'h40));            // E46
        vq.push_back(mk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));            // E0'
        repeat (4) vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'h40));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b11, 7'h7F));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, 7'h40));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].ld, vq[i].o, vq[i].t, vq[i].b, $sformatf("v%0d", i));
            chk($sformatf("v%0d_tbl_an", i), {5'd0, an}, {5'd0, vq[i].an});
            chk($sformatf("v%0d_tbl_seg", i), seg, vq[i].seg);
        end

        // Random traffic: sparse resets, frequent loads, live blanking toggles.
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 $sformatf("r%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Downstream consumer of the binary-to-BCD converter. Captures the two BCD digits (ones, tens) on a load strobe, decodes each to seven-segment patterns, and time-multiplexes them onto a two-digit common-anode display. The block has a refresh prescaler and a ghost-suppression gap between digit slots. Its outputs drive the board pins directly.

## Interface
Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit is lit per slot; must be ≥ 2.
- GAP_CYCLES, default 16: all-anodes-off cycles between slots; must be ≥ 1.

Ports:
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- load  in  1: when high, capture digit_ones and digit_tens on this edge.
- digit_ones  in  4: BCD ones digit, from the converter's low-digit output.
- digit_tens  in  4: BCD tens digit, from the converter's high-digit output.
- blank_lz  in  1: when high, blank the tens digit if the latched tens value is 0.
- seg  out  7: active-low segments, seg[0]=a … seg[6]=g; registered.
- an  out  2: active-low anodes, an[0]=ones, an[1]=tens; registered.

## Operation
- Digit registers: ones_q and tens_q, 4 bits each, reset to 0. On load=1 (rst=0) both are written together. Otherwise they hold.
- FSM states: GAP_TO_ONES, SHOW_ONES, GAP_TO_TENS, SHOW_TENS. Reset state is GAP_TO_ONES.
- Slot counter cnt:
  - Width is $clog2 of the larger of REFRESH_DIV and GAP_CYCLES.
  - Resets to 0 and clears to 0 on every state change.
- Transitions:
  - GAP_* → next SHOW_* when cnt == GAP_CYCLES-1.
  - SHOW_* → next GAP_* when cnt == REFRESH_DIV-1.
  - The sequence is cyclic: GAP_TO_ONES → SHOW_ONES → GAP_TO_TENS → SHOW_TENS → GAP_TO_ONES.
- Output computation, registered from the current state and digit registers:
  - GAP_*: an=2'b11, seg=7'h7F.
  - SHOW_ONES: an=2'b10, seg=decode(ones_q).
  - SHOW_TENS: an=2'b01, seg=decode(tens_q), except seg=7'h7F when blank_lz=1 and tens_q==0. The anode is still asserted in that case.
- Decode (active-low):
  - 0=7'b1000000
  - 1=7'b1111001
  - 2=7'b0100100
  - 3=7'b0110000
  - 4=7'b0011001
  - 5=7'b0010010
  - 6=7'b0000010
  - 7=7'b1111000
  - 8=7'b0000000
  - 9=7'b0010000
  - 10–15 (invalid BCD) = dash 7'b0111111
- Boundary conditions:
  - load during a SHOW slot: the new value appears on seg one cycle after the capture edge if that digit is currently shown. There is no wait for a slot boundary.
  - load held high continuously: the digit registers track the inputs every cycle.
  - blank_lz is sampled live, not latched.

## Timing
- Reset values: seg=7'h7F, an=2'b11, ones_q=tens_q=0, state GAP_TO_ONES, cnt=0.
- Reset mid-operation: on the next edge the block returns to the reset state and reset output values, regardless of FSM position.
- Output latency: one cycle after the state/data change.
- Edge numbering: let E0 be the first edge with rst=0.
  - Outputs stay dark through E0+GAP_CYCLES-1.
  - The ones slot is visible after edges E(GAP) … E(GAP+REFRESH_DIV-1).
- Full period is 2·(REFRESH_DIV+GAP_CYCLES) cycles.
- Each digit is lit for exactly REFRESH_DIV consecutive cycles per period.
- The two anodes are never simultaneously low.

## Structure
- Shared package seven_seg_pkg holds:
  - the state enum scan_state_t;
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the 16-entry decode function/table.
- Sub-module bcd_to_seg: purely combinational 4-bit → 7-bit active-low decoder. The driver instantiates it once and muxes ones_q or tens_q into it by state.

## Test plan
All scenarios use REFRESH_DIV=4, GAP_CYCLES=1.
- Reset then run, no load:
  - After E0: an=11.
  - After E1–E4: an=10, seg=7'b1000000.
  - After E5: an=11.
  - After E6–E9: an=01, seg=7'b1000000.
  - After E10: an=11.
- Load ones=7, tens=1 once, then observe a full period:
  - Ones slot: seg=7'b1111000.
  - Tens slot: seg=7'b1111001.
  - Each slot lasts exactly 4 cycles; anodes are never both low.
- Load ones=5, tens=0 with blank_lz=1:
  - Tens slot: an=01, seg=7'h7F.
  - Then set blank_lz=0: tens slot shows seg=7'b1000000.
- Load ones=12 (invalid): ones slot seg=7'b0111111.
- Load ones=3 on the 2nd cycle of a SHOW_ONES slot that was showing 8:
  - seg changes from 7'b0000000 to 7'b0110000 on the next edge.
  - The slot still ends at its original time.
- Assert rst for one cycle during SHOW_TENS:
  - The next edge gives an=11, seg=7'h7F, and digit registers 0.
  - The sequence restarts with the ones slot visible after E1 following release.
